// File: rtl/wacc_pkg.sv
// Shared types and helpers for the masked weight accumulator: FSM states, lane-count default,
// randomness sizing and share-major packing indices.
package wacc_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} wacc_state_e;

  localparam int ADD_LAT_DEF = 4;

  // Number of share pairs (i<j); each masked AND gadget consumes one fresh bit per pair.
  function automatic int pair_cnt(input int nd);
    return nd * (nd - 1) / 2;
  endfunction

  // Three DOM AND gadgets plus one refresh, each consuming pair_cnt bits.
  function automatic int rnd_w(input int nd);
    return 4 * pair_cnt(nd);
  endfunction

  // Share-major packing: bit b, share i lives at index nd*b + i.
  function automatic int sh_idx(input int nd, input int b, input int i);
    return nd * b + i;
  endfunction

  // Linear index of the share pair (lo, hi) with lo < hi.
  function automatic int pair_idx(input int nd, input int lo, input int hi);
    return lo * nd - lo * (lo + 1) / 2 + (hi - lo - 1);
  endfunction

endpackage

// File: rtl/adder_2_3_bit.sv
// Pipelined d-share Boolean-masked adder: 3-bit a plus 2-bit b, result mod 8, fixed latency ADD_LAT (>= 3).
// Carries use domain-oriented AND gadgets with registered cross-domain terms; shares are never recombined.
module adder_2_3_bit
  import wacc_pkg::*;
#(
  parameter int d = 2,
  parameter int ADD_LAT = ADD_LAT_DEF,
  localparam int NP = pair_cnt(d),
  localparam int RND_W = rnd_w(d)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3*d-1:0]   a,
  input  logic [2*d-1:0]   b,
  input  logic [RND_W-1:0] rnd,
  output logic [3*d-1:0]   c
);

  logic [NP-1:0] r_g0, r_g1, r_t, r_ref;
  assign r_g0  = rnd[NP-1:0];
  assign r_g1  = rnd[2*NP-1:NP];
  assign r_t   = rnd[3*NP-1:2*NP];
  assign r_ref = rnd[4*NP-1:3*NP];

  function automatic logic [d*d-1:0] dom_terms(input logic [d-1:0] x, input logic [d-1:0] y,
                                               input logic [NP-1:0] r);
    logic [d*d-1:0] t;
    t = '0;
    for (int i = 0; i < d; i++) begin
      for (int j = 0; j < d; j++) begin
        if (i == j) t[i*d+j] = x[i] & y[j];
        else        t[i*d+j] = (x[i] & y[j]) ^ r[pair_idx(d, (i < j) ? i : j, (i < j) ? j : i)];
      end
    end
    return t;
  endfunction

  function automatic logic [d-1:0] dom_fold(input logic [d*d-1:0] t);
    logic [d-1:0] f;
    f = '0;
    for (int i = 0; i < d; i++) f[i] = ^t[i*d +: d];
    return f;
  endfunction

  function automatic logic [d-1:0] refresh(input logic [d-1:0] x, input logic [NP-1:0] r);
    logic [d-1:0] y;
    y = x;
    for (int i = 0; i < d; i++) begin
      for (int j = i + 1; j < d; j++) begin
        y[i] = y[i] ^ r[pair_idx(d, i, j)];
        y[j] = y[j] ^ r[pair_idx(d, i, j)];
      end
    end
    return y;
  endfunction

  logic [d-1:0] a0, a1, a2, b0, b1;
  always_comb begin
    a0 = '0; a1 = '0; a2 = '0; b0 = '0; b1 = '0;
    for (int i = 0; i < d; i++) begin
      a0[i] = a[sh_idx(d, 0, i)];
      a1[i] = a[sh_idx(d, 1, i)];
      a2[i] = a[sh_idx(d, 2, i)];
      b0[i] = b[sh_idx(d, 0, i)];
      b1[i] = b[sh_idx(d, 1, i)];
    end
  end

  // Stage 1: generate terms g0 = a0&b0, g1 = a1&b1; propagate p1 = a1^b1.
  logic [d*d-1:0] g0_q, g1_q;
  logic [d-1:0]   s0_q1, p1_q1, a2_q1;
  // Stage 2: carry into bit 2 needs c0&p1; c0 is the folded g0.
  logic [d*d-1:0] t_q;
  logic [d-1:0]   g1_q2, s0_q2, s1_q2, a2_q2;
  logic [d-1:0]   g0_sh;
  assign g0_sh = dom_fold(g0_q);

  logic [d-1:0]   s2, s0_r;
  logic [3*d-1:0] sum3;
  always_comb begin
    s2   = a2_q2 ^ g1_q2 ^ dom_fold(t_q);
    // Bit 0 is XOR-only, so it gets a fresh remask every pass around the ring.
    s0_r = refresh(s0_q2, r_ref);
    sum3 = '0;
    for (int i = 0; i < d; i++) begin
      sum3[sh_idx(d, 0, i)] = s0_r[i];
      sum3[sh_idx(d, 1, i)] = s1_q2[i];
      sum3[sh_idx(d, 2, i)] = s2[i];
    end
  end

  logic [3*d-1:0] pipe_q [ADD_LAT-2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g0_q  <= '0;
      g1_q  <= '0;
      s0_q1 <= '0;
      p1_q1 <= '0;
      a2_q1 <= '0;
      t_q   <= '0;
      g1_q2 <= '0;
      s0_q2 <= '0;
      s1_q2 <= '0;
      a2_q2 <= '0;
      for (int n = 0; n < ADD_LAT - 2; n++) pipe_q[n] <= '0;
    end else begin
      g0_q  <= dom_terms(a0, b0, r_g0);
      g1_q  <= dom_terms(a1, b1, r_g1);
      s0_q1 <= a0 ^ b0;
      p1_q1 <= a1 ^ b1;
      a2_q1 <= a2;
      t_q   <= dom_terms(g0_sh, p1_q1, r_t);
      g1_q2 <= dom_fold(g1_q);
      s0_q2 <= s0_q1;
      s1_q2 <= p1_q1 ^ g0_sh;
      a2_q2 <= a2_q1;
      pipe_q[0] <= sum3;
      for (int n = 1; n < ADD_LAT - 2; n++) pipe_q[n] <= pipe_q[n-1];
    end
  end

  assign c = pipe_q[ADD_LAT-3];

endmodule

// File: rtl/masked_weight_accumulator.sv
// Accumulates d-share masked 2-bit counts into ADD_LAT interleaved masked mod-8 lane sums using one
// recirculating pipelined adder. Optional feature macro: WACC_BEAT_COUNT_EN (adds public beat_cnt).
module masked_weight_accumulator
  import wacc_pkg::*;
#(
  parameter int d = 2,
  parameter int ADD_LAT = ADD_LAT_DEF,
  localparam int RND_W = rnd_w(d),
  localparam int LANE_W = $clog2(ADD_LAT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*d-1:0]    in_data,
  input  logic              in_last,
  input  logic [RND_W-1:0]  rnd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3*d-1:0]    out_data,
  output logic [LANE_W-1:0] out_lane,
`ifdef WACC_BEAT_COUNT_EN
  output logic [15:0]       beat_cnt,
`endif
  output logic              done
);

  wacc_state_e       state_q;
  logic [LANE_W-1:0] slot_q, drain_cnt_q;
  logic              first_round_q;
  logic [ADD_LAT-1:0] emitted_q;

  logic [3*d-1:0] add_a, add_c;
  logic [2*d-1:0] add_b;
  logic           in_fire, out_fire, slot_wrap, capture, all_done;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign slot_wrap = (slot_q == LANE_W'(ADD_LAT - 1));
  // Stale ring contents are replaced by zero during the first pass after start.
  assign add_a     = first_round_q ? '0 : add_c;
  assign add_b     = in_fire ? in_data : '0;
  assign capture   = (state_q == OUT) && !out_valid && !emitted_q[slot_q];
  assign all_done  = &(emitted_q | (ADD_LAT'(1) << out_lane));

  adder_2_3_bit #(
    .d       (d),
    .ADD_LAT (ADD_LAT)
  ) u_adder (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (add_a),
    .b     (add_b),
    .rnd   (rnd),
    .c     (add_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      slot_q        <= '0;
      drain_cnt_q   <= '0;
      first_round_q <= 1'b0;
      emitted_q     <= '0;
      in_ready      <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_lane      <= '0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_q == IDLE) slot_q <= '0;
      else                 slot_q <= slot_wrap ? '0 : slot_q + 1'b1;
      if (first_round_q && slot_wrap) first_round_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q       <= ACCUM;
            in_ready      <= 1'b1;
            first_round_q <= 1'b1;
            emitted_q     <= '0;
          end
        end
        ACCUM: begin
          if (in_fire && in_last) begin
            state_q     <= DRAIN;
            in_ready    <= 1'b0;
            drain_cnt_q <= '0;
          end
        end
        DRAIN: begin
          // One full ring revolution after the last beat, every lane holds its final sum.
          if (drain_cnt_q == LANE_W'(ADD_LAT - 1)) state_q <= OUT;
          else                                     drain_cnt_q <= drain_cnt_q + 1'b1;
        end
        OUT: begin
          if (out_fire) begin
            out_valid           <= 1'b0;
            emitted_q[out_lane] <= 1'b1;
            if (all_done) begin
              state_q <= IDLE;
              done    <= 1'b1;
            end
          end else if (capture) begin
            out_valid <= 1'b1;
            out_data  <= add_c;
            out_lane  <= slot_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef WACC_BEAT_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              beat_cnt <= '0;
    else if (state_q == IDLE && start)       beat_cnt <= '0;
    else if (in_fire && beat_cnt != 16'hFFFF) beat_cnt <= beat_cnt + 16'd1;
  end
`endif

endmodule
